// File: rtl/mul_arbiter_pkg.sv
// Shared constants and pipeline stage payloads for the round-robin multiplier arbiter.
package mul_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned DATA_LEN_DEF = 8;
    localparam int unsigned RES_W        = 2 * DATA_LEN_DEF;
    localparam int unsigned ID_W         = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    // Stage 1: captured request operands and owner id
    typedef struct packed {
        logic                    valid;
        logic [ID_W-1:0]         id;
        logic [DATA_LEN_DEF-1:0] op1;
        logic [DATA_LEN_DEF-1:0] op2;
    } s1_t;

    // Stage 2: finished product and owner id
    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [RES_W-1:0] product;
    } s2_t;

endpackage

// File: rtl/mul_4to2_tree.sv
// Combinational unsigned multiplier: partial products reduced by 4:2 compressors, one final add.
module mul_4to2_tree #(
    parameter int unsigned DATA_LEN = 8
) (
    input  logic [DATA_LEN-1:0]   i_op1,
    input  logic [DATA_LEN-1:0]   i_op2,
    output logic [2*DATA_LEN-1:0] o_product
);

    localparam int unsigned RES_W  = 2 * DATA_LEN;
    // Partial-product count padded to whole compressor groups; padding rows stay zero
    localparam int unsigned NPP    = ((DATA_LEN + 3) / 4) * 4;
    localparam int unsigned LEVELS = (NPP > 1) ? $clog2(NPP) : 1;

    logic [RES_W-1:0] w_cur [NPP];
    logic [RES_W-1:0] w_nxt [NPP];

    // 3:2 carry-save adder; returns {carry, sum}, sum+carry equals a+b+c modulo 2^RES_W
    function automatic logic [2*RES_W-1:0] csa(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b,
                                               input logic [RES_W-1:0] c);
        logic [RES_W-1:0] carry;
        carry = ((a & b) | (a & c) | (b & c)) << 1;
        return {carry, a ^ b ^ c};
    endfunction

    // 4:2 compressor built from two chained carry-save adders
    function automatic logic [2*RES_W-1:0] cmp42(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b,
                                                 input logic [RES_W-1:0] c,
                                                 input logic [RES_W-1:0] d);
        logic [2*RES_W-1:0] t;
        t = csa(a, b, c);
        return csa(t[RES_W-1:0], t[2*RES_W-1:RES_W], d);
    endfunction

    // Build partial products, then halve the row count per level; extra levels see zero rows
    always_comb begin
        for (int i = 0; i < int'(NPP); i++) begin
            w_cur[i] = '0;
            w_nxt[i] = '0;
        end
        for (int i = 0; i < int'(DATA_LEN); i++) begin
            w_cur[i] = i_op2[i] ? (RES_W'(i_op1) << i) : '0;
        end
        for (int lvl = 0; lvl < int'(LEVELS); lvl++) begin
            for (int i = 0; i < int'(NPP); i++) begin
                w_nxt[i] = '0;
            end
            for (int g = 0; g < int'(NPP / 4); g++) begin
                {w_nxt[2*g+1], w_nxt[2*g]} = cmp42(w_cur[4*g], w_cur[4*g+1],
                                                   w_cur[4*g+2], w_cur[4*g+3]);
            end
            for (int i = 0; i < int'(NPP); i++) begin
                w_cur[i] = w_nxt[i];
            end
        end
        o_product = w_cur[0] + w_cur[1];
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiply pipeline with ready/valid on both sides.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][DATA_LEN-1:0]   req_op1,
    input  logic [NUM_REQ-1:0][DATA_LEN-1:0]   req_op2,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [ID_W-1:0]                    res_id,
    output logic [2*DATA_LEN-1:0]              res_product,
    output logic                               busy
);

    // Stage payload structs are sized from the package defaults; parameters must match them.

    s1_t              r_s1;
    s2_t              r_s2;
    logic [ID_W-1:0]  r_last_grant;

    logic             w_s2_out;
    logic             w_s2_load;
    logic             w_s1_adv;
    logic             w_s1_load;
    logic             w_grant_ok;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_idx;
    logic             w_xfer;
    logic [RES_W-1:0] w_product;

    assign w_s2_out  = r_s2.valid & res_ready;
    assign w_s2_load = ~r_s2.valid | w_s2_out;
    assign w_s1_adv  = r_s1.valid & w_s2_load;
    assign w_s1_load = ~r_s1.valid | w_s1_adv;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % int'(NUM_REQ));
            if (!w_grant_ok && req_valid[w_idx]) begin
                w_grant_ok = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    // Offer a single grant only when stage 1 can accept this cycle
    always_comb begin
        req_ready = '0;
        if (!rst && w_s1_load && w_grant_ok) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_xfer = |(req_valid & req_ready);

    mul_4to2_tree #(
        .DATA_LEN (DATA_LEN)
    ) u_mul (
        .i_op1     (r_s1.op1),
        .i_op2     (r_s1.op2),
        .o_product (w_product)
    );

    // Pipeline stages and round-robin pointer; pointer moves only on an accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            if (w_s2_load) begin
                r_s2.valid <= r_s1.valid;
                if (r_s1.valid) begin
                    r_s2.id      <= r_s1.id;
                    r_s2.product <= w_product;
                end
            end
            if (w_s1_load) begin
                r_s1.valid <= w_xfer;
                if (w_xfer) begin
                    r_s1.id      <= w_grant_id;
                    r_s1.op1     <= req_op1[w_grant_id];
                    r_s1.op2     <= req_op2[w_grant_id];
                    r_last_grant <= w_grant_id;
                end
            end
        end
    end

    assign res_valid   = r_s2.valid;
    assign res_id      = r_s2.id;
    assign res_product = r_s2.product;
    assign busy        = r_s1.valid | r_s2.valid;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 4, number of requesters
- DATA_LEN, 8, operand width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge
- rst, in, 1, synchronous, active-high reset
- req_valid, in, NUM_REQ, per-requester request valid
- req_ready, out, NUM_REQ, per-requester accept
- req_op1, in, NUM_REQ x DATA_LEN, per-requester multiplicand
- req_op2, in, NUM_REQ x DATA_LEN, per-requester multiplier
- res_valid, out, 1, result valid
- res_ready, in, 1, result consumer accept
- res_id, out, clog2(NUM_REQ), index of requester owning the result
- res_product, out, 2*DATA_LEN, unsigned product op1*op2
- busy, out, 1, any pipeline stage occupied
REQ-003 One clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 A request transfer SHALL occur on a cycle where req_valid[i] && req_ready[i]; a result transfer SHALL occur where res_valid && res_ready.
REQ-005 At most one req_ready bit SHALL be high per cycle (one-hot or zero).
REQ-006 req_ready[i] SHALL be combinational from req_valid, the round-robin pointer and pipeline state, never from req_op1/req_op2.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, wrapping; first valid requester wins.
REQ-008 last_grant SHALL update only on an actual request transfer; a grant without transfer does not move it.
REQ-009 Datapath SHALL be a two-stage pipeline: S1 registers op1, op2, id; S2 registers the unsigned 2*DATA_LEN product of S1 operands and S1 id.
REQ-010 Outputs res_valid, res_id, res_product SHALL come directly from S2 registers.
REQ-011 S2 SHALL load when S2 empty or S2 transfers out this cycle; S1 SHALL load when S1 empty or S1 moves to S2 this cycle.
REQ-012 Grant SHALL be offered only when S1 can load (S1 empty or advancing).
REQ-013 Latency: request transferred in cycle N SHALL present res_valid in cycle N+2 when res_ready held high.
REQ-014 Throughput SHALL be one request per cycle with res_ready high; no bubbles inserted.
REQ-015 res_valid low with res_ready low: S1 SHALL still advance into empty S2 (bubble collapse).
REQ-016 With res_ready low and both stages full, all req_ready SHALL be low and S1/S2 contents SHALL hold stable.
REQ-017 Results SHALL leave in acceptance order; no request lost or duplicated.
REQ-018 Products SHALL be exact: 255*255 = 65025 (0xFE01), no truncation.
REQ-019 busy SHALL equal S1 valid OR S2 valid.
REQ-020 A requester dropping req_valid before transfer SHALL lose the grant without pointer change.

Reset
REQ-021 On rst high at a clock edge: S1/S2 valid flags cleared, res_valid=0, busy=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-022 During rst all req_ready SHALL be 0; S1/S2 data registers and res_id/res_product SHALL reset to 0.
REQ-023 Reset mid-operation SHALL discard in-flight results; first post-reset request behaves as after power-up.

Structure
REQ-024 A shared package SHALL hold DATA_LEN default, result-width and id-width constants, and the S1/S2 stage struct typedefs (valid, id, operands/product).
REQ-025 The multiplier SHALL be one sub-module instance, mul_4to2_tree, between S1 and S2; the arbiter itself contains no arithmetic.
REQ-026 Round-robin select SHALL be a function or always_comb block inside mul_arbiter, not a separate module.

Verification
REQ-027 Single request: req 2 op1=13 op2=11, res_ready=1 -> two cycles later res_valid=1, res_id=2, res_product=143.
REQ-028 All four valid constantly, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; results in same id order, one per cycle.
REQ-029 Backpressure: two accepted then res_ready=0 for 5 cycles -> req_ready all 0 from stall, res_product/res_id stable, both results emerge in order after release.
REQ-030 Corners: 255*255 -> 65025; 0*200 -> 0; 1*255 -> 255.
REQ-031 Reset mid-flight: rst with S1 and S2 full -> next cycle res_valid=0, busy=0; new request to req 3 while req 0 also valid -> req 0 granted first.
REQ-032 Random stimulus with scoreboard: every transferred request yields exactly one matching (id, product) in order; req_ready never multi-hot.
